// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back stage scalar and vector register files with byte-lane insert
// Optional feature: define WB_BYPASS_EN for same-cycle write-through forwarding to read ports.
module wb_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Do,
   input  logic [7:0]  Dob,
   input  logic [31:0] ALU_Result,
   input  logic        WE_C,
   input  logic        WE_V,
   input  logic        SEL_DAT,
   input  logic        SEL_STO,
   input  logic        SEL_C,
   input  logic [3:0]  Rg,
   input  logic [3:0]  RA_A,
   input  logic [3:0]  RA_B,
   output logic [31:0] RD_A,
   output logic [31:0] RD_B,
   input  logic [3:0]  RV,
   output logic [31:0] VD,
   output logic [1:0]  LANE,
   output logic        VREADY
);

   logic [31:0] s_mem [16];
   logic [31:0] v_mem [16];
   logic [3:0]  last_rg;
   logic [31:0] wd;
   logic [1:0]  ins_lane;
   logic [31:0] v_merged;
   logic [31:0] v_next;

   // Write-data mux: ALU result, full memory word, or zero-extended memory byte.
   always_comb begin
      wd = ALU_Result;
      if (SEL_DAT) begin
         wd = SEL_STO ? {24'b0, Dob} : Do;
      end
   end

   // Lane for this insert restarts at 0 when the target register changes; merge Dob into that lane.
   always_comb begin
      ins_lane = (Rg == last_rg) ? LANE : 2'd0;
      v_merged = v_mem[Rg];
      case (ins_lane)
         2'd0:    v_merged[7:0]   = Dob;
         2'd1:    v_merged[15:8]  = Dob;
         2'd2:    v_merged[23:16] = Dob;
         default: v_merged[31:24] = Dob;
      endcase
      v_next = SEL_C ? v_merged : wd;
   end

   // Scalar file; entry 0 is never written so it always reads zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            s_mem[i] <= 32'b0;
         end
      end else if (WE_C && (Rg != 4'd0)) begin
         s_mem[Rg] <= wd;
      end
   end

   // Vector file; full-word write or single byte-lane insert.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            v_mem[i] <= 32'b0;
         end
      end else if (WE_V) begin
         v_mem[Rg] <= v_next;
      end
   end

   // Lane pointer, last-insert register and the lane-3 completion pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         LANE    <= 2'd0;
         last_rg <= 4'd0;
         VREADY  <= 1'b0;
      end else begin
         VREADY <= WE_V && SEL_C && (ins_lane == 2'd3);
         if (WE_V) begin
            if (SEL_C) begin
               LANE    <= ins_lane + 2'd1;
               last_rg <= Rg;
            end else begin
               LANE <= 2'd0;
            end
         end
      end
   end

`ifdef WB_BYPASS_EN
   // Read ports forward the value being written this cycle when addresses match.
   always_comb begin
      RD_A = s_mem[RA_A];
      RD_B = s_mem[RA_B];
      VD   = v_mem[RV];
      if (!rst) begin
         if (WE_C && (Rg != 4'd0) && (RA_A == Rg)) RD_A = wd;
         if (WE_C && (Rg != 4'd0) && (RA_B == Rg)) RD_B = wd;
         if (WE_V && (RV == Rg))                   VD   = v_next;
      end
   end
`else
   // Read ports return stored contents only.
   always_comb begin
      RD_A = s_mem[RA_A];
      RD_B = s_mem[RA_B];
      VD   = v_mem[RV];
   end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard testbench for wb_regfile with a behavioural reference model
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] d_o;
   logic [7:0]  dob;
   logic [31:0] alu;
   logic        we_c, we_v, sel_dat, sel_sto, sel_c;
   logic [3:0]  rg, ra_a, ra_b, rv;
   logic [31:0] rd_a, rd_b, vd;
   logic [1:0]  lane;
   logic        vready;

   wb_regfile dut (
      .clk        (clk),
      .rst        (rst),
      .Do         (d_o),
      .Dob        (dob),
      .ALU_Result (alu),
      .WE_C       (we_c),
      .WE_V       (we_v),
      .SEL_DAT    (sel_dat),
      .SEL_STO    (sel_sto),
      .SEL_C      (sel_c),
      .Rg         (rg),
      .RA_A       (ra_a),
      .RA_B       (ra_b),
      .RD_A       (rd_a),
      .RD_B       (rd_b),
      .RV         (rv),
      .VD         (vd),
      .LANE       (lane),
      .VREADY     (vready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] v;
      logic [1:0]  lane;
      logic        vr;
   } exp_t;

   exp_t exp_q[$];
   logic probe = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state
   logic [31:0] m_s [16];
   logic [31:0] m_v [16];
   int          m_lane;
   int          m_last;
   logic        m_vr;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   // Monitor: pops one expectation whenever the stimulus presents a probe.
   always @(negedge clk) begin
      if (probe) begin
         if (exp_q.size() == 0) begin
            chk("queue_underflow", 32'd0, 32'd1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("RD_A", rd_a, e.a);
            chk("RD_B", rd_b, e.b);
            chk("VD", vd, e.v);
            chk("LANE", {30'b0, lane}, {30'b0, e.lane});
            chk("VREADY", {31'b0, vready}, {31'b0, e.vr});
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_s[i] = 32'd0;
         m_v[i] = 32'd0;
      end
      m_lane = 0;
      m_last = 0;
      m_vr   = 1'b0;
   endtask

   function automatic logic [31:0] model_wd();
      if (!sel_dat) return alu;
      if (sel_sto)  return {24'd0, dob};
      return d_o;
   endfunction

   function automatic int model_ins_lane();
      return (int'(rg) == m_last) ? m_lane : 0;
   endfunction

   function automatic logic [31:0] model_vnext();
      int l;
      logic [31:0] mask;
      if (!sel_c) return model_wd();
      l = model_ins_lane();
      mask = 32'hFF << (8 * l);
      return (m_v[rg] & ~mask) | ({24'd0, dob} << (8 * l));
   endfunction

   // One clock: publish expected read-port view, let the edge happen, then commit to the model.
   task automatic step();
      exp_t e;
      logic [31:0] wdm, nv;
      if (rst) model_reset();
      wdm = model_wd();
      nv  = model_vnext();
      e.a = m_s[ra_a];
      e.b = m_s[ra_b];
      e.v = m_v[rv];
      e.lane = m_lane[1:0];
      e.vr = m_vr;
`ifdef WB_BYPASS_EN
      if (!rst) begin
         if (we_c && rg != 0 && ra_a == rg) e.a = wdm;
         if (we_c && rg != 0 && ra_b == rg) e.b = wdm;
         if (we_v && rv == rg) e.v = nv;
      end
`endif
      exp_q.push_back(e);
      probe = 1'b1;
      @(posedge clk);
      if (!rst) begin
         if (we_c && rg != 0) m_s[rg] = wdm;
         if (we_v) begin
            if (sel_c) begin
               int l;
               l = model_ins_lane();
               m_v[rg] = nv;
               m_vr   = (l == 3);
               m_lane = (l + 1) % 4;
               m_last = rg;
            end else begin
               m_v[rg] = nv;
               m_vr   = 1'b0;
               m_lane = 0;
            end
         end else begin
            m_vr = 1'b0;
         end
      end
      #1;
      probe = 1'b0;
   endtask

   task automatic idle();
      we_c = 0; we_v = 0; sel_dat = 0; sel_sto = 0; sel_c = 0;
      rg = 0; d_o = 0; dob = 0; alu = 0;
   endtask

   task automatic insert(input logic [3:0] r, input logic [7:0] b);
      idle();
      we_v = 1; sel_c = 1; rg = r; dob = b;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle();
      ra_a = 0; ra_b = 0; rv = 0;
      model_reset();
      @(posedge clk);
      #1;
      step();
      rst = 1'b0;

      // ALU write to S[5], read back next cycle
      we_c = 1; rg = 5; alu = 32'h12345678; ra_a = 5;
      step();
      idle(); ra_a = 5;
      step();

      // Zero-extended byte store to S[3]; write to S[0] ignored
      we_c = 1; rg = 3; sel_dat = 1; sel_sto = 1; d_o = 32'hFFFFFFFF; dob = 8'hA5;
      step();
      idle(); we_c = 1; rg = 0; alu = 32'hDEADBEEF; ra_a = 0; ra_b = 3;
      step();
      idle(); ra_a = 0; ra_b = 3;
      step();

      // Four-lane insert into V[2] with completion pulse
      rv = 2;
      insert(2, 8'h11);
      insert(2, 8'h22);
      insert(2, 8'h33);
      insert(2, 8'h44);
      idle();
      step();
      step();

      // Fresh reset, two inserts into V[2], then switch to V[7]
      rst = 1; idle();
      step();
      rst = 0;
      insert(2, 8'h11);
      insert(2, 8'h22);
      rv = 7;
      insert(7, 8'h99);
      idle(); rv = 2;
      step();
      rv = 7;
      step();

      // Asynchronous reset in the middle of an insert sequence, writes held active
      insert(2, 8'h55);
      insert(2, 8'h66);
      ra_a = 3; ra_b = 5; rv = 2;
      we_c = 1; we_v = 1; sel_c = 1; rg = 2; dob = 8'h77;
      rst = 1;
      step();
      rst = 0;
      idle();
      step();

      // Same-cycle write and read of S[4]
      we_c = 1; rg = 4; alu = 32'h11111111;
      step();
      we_c = 1; rg = 4; alu = 32'hCAFEF00D; ra_b = 4;
      step();
      idle(); ra_b = 4;
      step();

      // Simultaneous scalar and vector writes
      we_c = 1; we_v = 1; sel_c = 0; rg = 9; alu = 32'h0BADF00D; ra_a = 9; rv = 9;
      step();
      idle(); ra_a = 9; rv = 9;
      step();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         idle();
         rst     = ($urandom_range(0, 99) == 0);
         we_c    = $urandom_range(0, 1);
         we_v    = ($urandom_range(0, 2) != 0);
         sel_dat = $urandom_range(0, 1);
         sel_sto = $urandom_range(0, 1);
         sel_c   = ($urandom_range(0, 3) != 0);
         rg      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (($urandom_range(0, 1) == 0) ? 4'd2 : 4'd7);
         d_o     = $urandom;
         dob     = 8'($urandom);
         alu     = $urandom;
         ra_a    = ($urandom_range(0, 1) == 0) ? rg : 4'($urandom);
         ra_b    = 4'($urandom);
         rv      = ($urandom_range(0, 1) == 0) ? rg : 4'($urandom);
         step();
      end
      rst = 0;
      idle();
      step();

      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 Do  in  32  memory word from MEM/WB register.
REQ-004 Dob  in  8  memory byte from MEM/WB register.
REQ-005 ALU_Result  in  32  ALU result from MEM/WB register.
REQ-006 WE_C  in  1  scalar register-file write enable, active-high.
REQ-007 WE_V  in  1  vector register-file write enable, active-high.
REQ-008 SEL_DAT  in  1  source select: 0 = ALU_Result, 1 = memory data.
REQ-009 SEL_STO  in  1  memory width select: 0 = Do word, 1 = Dob zero-extended to 32.
REQ-010 SEL_C  in  1  vector write mode: 0 = full 32-bit word, 1 = byte-lane insert of Dob.
REQ-011 Rg  in  4  destination register index.
REQ-012 RA_A, RA_B  in  4 each  scalar read addresses; RD_A, RD_B  out  32 each  scalar read data.
REQ-013 RV  in  4  vector read address; VD  out  32  vector read data.
REQ-014 LANE  out  2  current byte-lane insert pointer.
REQ-015 VREADY  out  1  one-cycle pulse after lane 3 of a vector register is filled.

Function
REQ-016 Write data WD SHALL equal ALU_Result if SEL_DAT=0; Do if SEL_DAT=1, SEL_STO=0; {24'b0,Dob} if SEL_DAT=1, SEL_STO=1.
REQ-017 Scalar file: 16 x 32; WE_C=1 at rising edge SHALL write WD into S[Rg]; Rg=0 writes ignored, S[0] reads 0 always.
REQ-018 Scalar reads SHALL be combinational: RD_A=S[RA_A], RD_B=S[RA_B].
REQ-019 Vector file: 16 x 32, 4 byte lanes, lane 0 = bits 7:0; VD=V[RV] combinational; V0 writable.
REQ-020 WE_V=1, SEL_C=0: V[Rg] <= WD at edge; LANE <= 0.
REQ-021 WE_V=1, SEL_C=1: byte lane LANE of V[Rg] <= Dob, other lanes kept; LANE <= LANE+1 mod 4.
REQ-022 Lane pointer SHALL restart at 0 for an insert whose Rg differs from Rg of the previous insert (insert goes to lane 0, LANE <= 1).
REQ-023 VREADY SHALL be 1 for exactly the cycle after an insert into lane 3, else 0; pointer wraps 3->0 on that insert.
REQ-024 WE_C=1 and WE_V=1 same edge: both writes performed (scalar gets WD, vector per SEL_C); no priority.
REQ-025 WE_V=0 SHALL leave LANE, last-insert Rg, and vector file unchanged; WE_C has no effect on LANE.
REQ-026 Write latency: data written at edge N visible on read ports after edge N (without bypass, see REQ-031).

Reset
REQ-027 rst=1 SHALL immediately clear all S and V entries to 0, LANE to 0, VREADY to 0, last-insert Rg to 0.
REQ-028 Writes asserted while rst=1 SHALL be discarded; a byte-insert sequence interrupted by reset restarts at lane 0.
REQ-029 First write after rst deasserts SHALL occur at the first rising edge with rst=0.

Configuration
REQ-030 Macro WB_BYPASS_EN selects same-cycle write-through forwarding.
REQ-031 With WB_BYPASS_EN: if WE_C=1, Rg!=0, RA_x==Rg, RD_x SHALL equal WD combinationally; if WE_V=1, RV==Rg, VD SHALL equal the value being written (merged word for inserts).
REQ-032 Without WB_BYPASS_EN: read ports SHALL return stored contents only; no path from write inputs to read outputs.

Verification
REQ-033 Reset, then WE_C=1, Rg=5, SEL_DAT=0, ALU_Result=0x12345678; next cycle RA_A=5 -> RD_A=0x12345678.
REQ-034 WE_C=1, Rg=3, SEL_DAT=1, SEL_STO=1, Do=0xFFFFFFFF, Dob=0xA5 -> S[3]=0x000000A5; WE_C=1, Rg=0 -> RD_A for RA_A=0 stays 0.
REQ-035 Four inserts Rg=2, SEL_C=1, Dob=0x11,0x22,0x33,0x44 -> V[2]=0x44332211, VREADY high one cycle after 4th, LANE=0.
REQ-036 Two inserts to Rg=2, then insert Rg=7 Dob=0x99 -> V[7] lane0=0x99, LANE=1, V[2]=0x00002211 unchanged.
REQ-037 Mid-sequence (LANE=2) assert rst asynchronously between edges -> LANE=0, all reads 0 before next edge.
REQ-038 WB_BYPASS_EN defined: WE_C=1, Rg=4, WD=0xCAFEF00D, RA_B=4 same cycle -> RD_B=0xCAFEF00D; undefined -> RD_B=old S[4].
